fifo_wr_arb_ctrl: RTL and testbench
===================================

// Module: fifo_wr_arb_ctrl
// PURPOSE
//  Pointer/flag controller for the 16x8 FIFO storage array (sync write, combinational read).
//  Arbitrates two write requesters round-robin onto the single array write port.
//  Serves one reader and generates all array addresses and enables.
//  Reports occupancy, threshold flags and sticky overflow/underflow errors.
// PARAMETERS
//  DATA_W     8   data width; matches array word width
//  ADDR_W     4   array address width; depth = 2**ADDR_W = 16
//  AF_THRESH  14  almost_full asserted when count >= AF_THRESH
//  AE_THRESH  2   almost_empty asserted when count <= AE_THRESH
// PORTS
//  clk           in   1         single clock, rising edge
//  reset         in   1         asynchronous, active-low; all state cleared while 0
//  wr_req0       in   1         requester 0 push request
//  wr_data0      in   DATA_W    requester 0 push data
//  wr_gnt0       out  1         requester 0 push accepted this cycle
//  wr_req1       in   1         requester 1 push request
//  wr_data1      in   DATA_W    requester 1 push data
//  wr_gnt1       out  1         requester 1 push accepted this cycle
//  rd_req        in   1         pop request
//  rd_ack        out  1         pop accepted; rd_data valid this cycle
//  rd_data       out  DATA_W    head-of-FIFO data (= mem_rdata)
//  mem_we        out  1         array write enable
//  mem_waddr     out  ADDR_W    array write address
//  mem_wdata     out  DATA_W    array write data (mux of granted requester)
//  mem_full      out  1         array full input (= full)
//  mem_raddr     out  ADDR_W    array read address
//  mem_rdata     in   DATA_W    array combinational read data
//  full          out  1         registered; count == 2**ADDR_W
//  empty         out  1         registered; count == 0
//  almost_full   out  1         registered
//  almost_empty  out  1         registered
//  count         out  ADDR_W+1  registered occupancy, 0..16
//  err_clr       in   1         synchronous clear of ovf_err/udf_err
//  ovf_err       out  1         sticky: push requested while full
//  udf_err       out  1         sticky: pop requested while empty
// BEHAVIOUR
//  - Reset (reset=0): wptr=rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0,
//    errors=0, last_gnt=1 (requester 0 wins first contention). Array contents are not cleared.
//  - Pointers are ADDR_W+1 bits; low ADDR_W bits drive mem_waddr/mem_raddr. Wrap 15->0 is natural;
//    the MSB toggles on wrap. count is tracked separately and never exceeds 16.
//  - Grants are combinational from registered full:
//    full=1 -> no grant.
//    Only one requester active -> that requester is granted.
//    Both active -> requester != last_gnt is granted; last_gnt updates on every grant.
//  - push = wr_gnt0|wr_gnt1; mem_we=push; mem_wdata=granted data. Data written at the edge; wptr++.
//  - rd_ack = rd_req & ~empty. rd_data = mem_rdata at mem_raddr in the same cycle (zero latency).
//    rptr++ at the edge.
//  - count_next = count + push - pop.
//    Flags are registered from count_next, so they are valid the cycle after the edge.
//  - Push+pop in the same cycle: both proceed and count is unchanged.
//    When full, only the pop proceeds. When empty, only the push proceeds; the pushed word is
//    readable next cycle (no fall-through).
//  - ovf_err sets on (wr_req0|wr_req1)&full; udf_err sets on rd_req&empty.
//    If set and err_clr occur in the same cycle, set wins.
//  - Reset mid-operation: state clears immediately (asynchronous); grants and rd_ack drop with it.
//    No partial write occurs after reset asserts.
// TESTING
//  1. Reset, then 16 pushes from req0 with data 0x00..0x0F.
//     -> full=1 and count=16 after the 16th edge; almost_full rises when count reaches 14;
//     17th req -> wr_gnt0=0, ovf_err=1.
//  2. Both requesters held with req0 data 0xA0+n and req1 data 0xB0+n.
//     -> grants alternate 0,1,0,1...; pops return A0,B0,A1,B1...
//  3. Pop on empty after reset -> rd_ack=0, udf_err=1; err_clr for one cycle -> udf_err=0.
//  4. Fill to 16, then push+pop in the same cycle.
//     -> pop accepted, push not granted, count=15;
//     next cycle push+pop -> both accepted, count stays 15.
//  5. Stream 40 words through with random push/pop at count 8.
//     -> pointers wrap twice; data order preserved; count matches scoreboard every cycle.
//  6. Assert reset mid-stream at count=9 between clock edges.
//     -> count=0, empty=1, grants=0 immediately; first post-reset contention goes to req0.

Source files
------------

// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl: pointer/flag controller for a 16x8 FIFO array (sync write,
// combinational read). Two write requesters share the array write port under
// round-robin arbitration. One reader pops with zero-latency data.
module fifo_wr_arb_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req0,
  input  logic [DATA_W-1:0] wr_data0,
  output logic              wr_gnt0,
  input  logic              wr_req1,
  input  logic [DATA_W-1:0] wr_data1,
  output logic              wr_gnt1,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_full,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  input  logic              err_clr,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_T = CW'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_T = CW'(AE_THRESH);

  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic [ADDR_W:0] wptr_nxt;
  logic [ADDR_W:0] rptr_nxt;
  logic [ADDR_W:0] count_nxt;
  logic            last_gnt;   // 1: requester 1 was granted last, so requester 0 wins next tie
  logic            push;
  logic            pop;

  // Round-robin grant from registered full; everything is masked while reset is held
  always_comb begin
    wr_gnt0 = 1'b0;
    wr_gnt1 = 1'b0;
    if (reset && !full) begin
      if (wr_req0 && wr_req1) begin
        wr_gnt0 = last_gnt;
        wr_gnt1 = !last_gnt;
      end else begin
        wr_gnt0 = wr_req0;
        wr_gnt1 = wr_req1;
      end
    end
  end

  assign push      = wr_gnt0 | wr_gnt1;
  assign pop       = rd_req & ~empty & reset;
  assign rd_ack    = pop;
  assign rd_data   = mem_rdata;
  assign mem_we    = push;
  assign mem_wdata = wr_gnt1 ? wr_data1 : wr_data0;
  assign mem_waddr = wptr[ADDR_W-1:0];
  assign mem_raddr = rptr[ADDR_W-1:0];
  assign mem_full  = full;

  assign wptr_nxt  = wptr + CW'(push);
  assign rptr_nxt  = rptr + CW'(pop);
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Pointers, occupancy, registered flags, arbitration history and sticky errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      last_gnt     <= 1'b1;
      ovf_err      <= 1'b0;
      udf_err      <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      count        <= count_nxt;
      // Full/empty come from the wrap bit and the address bits; they always agree with count
      full         <= (wptr_nxt[ADDR_W] != rptr_nxt[ADDR_W]) &&
                      (wptr_nxt[ADDR_W-1:0] == rptr_nxt[ADDR_W-1:0]);
      empty        <= (wptr_nxt == rptr_nxt);
      almost_full  <= (count_nxt >= AF_T);
      almost_empty <= (count_nxt <= AE_T);
      if (push) begin
        last_gnt <= wr_gnt1;
      end
      // Set has priority over clear so an error in the clear cycle is not lost
      if ((wr_req0 | wr_req1) & full) begin
        ovf_err <= 1'b1;
      end else if (err_clr) begin
        ovf_err <= 1'b0;
      end
      if (rd_req & empty) begin
        udf_err <= 1'b1;
      end else if (err_clr) begin
        udf_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed testbench for fifo_wr_arb_ctrl with a behavioural 16x8 array.
module tb_fifo_wr_arb_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req0, wr_req1, rd_req, err_clr;
  logic [7:0] wr_data0, wr_data1;
  logic       wr_gnt0, wr_gnt1, rd_ack;
  logic [7:0] rd_data, mem_wdata, mem_rdata;
  logic       mem_we, mem_full;
  logic [3:0] mem_waddr, mem_raddr;
  logic       full, empty, almost_full, almost_empty, ovf_err, udf_err;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [16];
  logic [7:0] q [$];

  always #5 clk = ~clk;

  fifo_wr_arb_ctrl dut (
    .clk(clk), .reset(reset),
    .wr_req0(wr_req0), .wr_data0(wr_data0), .wr_gnt0(wr_gnt0),
    .wr_req1(wr_req1), .wr_data1(wr_data1), .wr_gnt1(wr_gnt1),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_full(mem_full), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .err_clr(err_clr), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  // Storage array: synchronous write, combinational read
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic push0(input logic [7:0] d);
    wr_req0 = 1'b1;
    wr_data0 = d;
    tick();
    wr_req0 = 1'b0;
  endtask

  initial begin
    int na, nb, popped, cyc, cnt_m;
    logic last_m, r0, r1, rd, e0, e1, ea;
    logic [7:0] d0, d1;

    reset = 1'b0; wr_req0 = 0; wr_req1 = 0; rd_req = 0; err_clr = 0;
    wr_data0 = '0; wr_data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_udf", udf_err, 0);
    reset = 1'b1;

    // Test 1: fill from requester 0, overflow, drain
    for (int n = 0; n < 16; n++) begin
      wr_req0 = 1'b1;
      wr_data0 = 8'(n);
      #1;
      chk("t1_gnt0", wr_gnt0, 1);
      tick();
      chk("t1_count", count, n + 1);
      chk("t1_af", almost_full, (n + 1) >= 14);
      chk("t1_ae", almost_empty, (n + 1) <= 2);
      chk("t1_full", full, n == 15);
    end
    #1;
    chk("t1_gnt0_full", wr_gnt0, 0);
    chk("t1_mem_full", mem_full, 1);
    chk("t1_mem_we_full", mem_we, 0);
    tick();
    chk("t1_ovf", ovf_err, 1);
    chk("t1_count16", count, 16);
    wr_req0 = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t1_rd_ack", rd_ack, 1);
      chk("t1_rd_data", rd_data, i);
      tick();
    end
    rd_req = 1'b0;
    chk("t1_empty", empty, 1);
    chk("t1_count0", count, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t1_ovf_clr", ovf_err, 0);

    // Test 2: both requesters contend, grants alternate starting with 0
    pulse_reset();
    na = 0; nb = 0;
    for (int k = 0; k < 8; k++) begin
      wr_req0 = 1'b1; wr_req1 = 1'b1;
      wr_data0 = 8'(8'hA0 + na);
      wr_data1 = 8'(8'hB0 + nb);
      #1;
      chk("t2_gnt0", wr_gnt0, (k % 2) == 0);
      chk("t2_gnt1", wr_gnt1, (k % 2) == 1);
      chk("t2_wdata", mem_wdata, ((k % 2) == 0) ? 8'(8'hA0 + na) : 8'(8'hB0 + nb));
      tick();
      if ((k % 2) == 0) na++; else nb++;
    end
    wr_req0 = 1'b0; wr_req1 = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_rd_data", rd_data, ((i % 2) == 0) ? 8'(8'hA0 + i / 2) : 8'(8'hB0 + i / 2));
      tick();
    end
    rd_req = 1'b0;
    chk("t2_empty", empty, 1);

    // Test 3: underflow, set-wins-over-clear, then clear
    pulse_reset();
    rd_req = 1'b1;
    #1;
    chk("t3_rd_ack", rd_ack, 0);
    tick();
    chk("t3_udf", udf_err, 1);
    err_clr = 1'b1;
    tick();
    chk("t3_udf_setwins", udf_err, 1);
    rd_req = 1'b0;
    tick();
    err_clr = 1'b0;
    chk("t3_udf_clr", udf_err, 0);

    // Test 4: push+pop when full, then push+pop at 15
    pulse_reset();
    for (int n = 0; n < 16; n++) push0(8'(n));
    chk("t4_full", full, 1);
    wr_req0 = 1'b1; wr_data0 = 8'h55; rd_req = 1'b1;
    #1;
    chk("t4_gnt0_full", wr_gnt0, 0);
    chk("t4_rd_ack", rd_ack, 1);
    chk("t4_rd_data", rd_data, 0);
    tick();
    chk("t4_count15", count, 15);
    chk("t4_nfull", full, 0);
    #1;
    chk("t4_gnt0", wr_gnt0, 1);
    chk("t4_rd_ack2", rd_ack, 1);
    chk("t4_rd_data2", rd_data, 1);
    tick();
    chk("t4_count15b", count, 15);
    wr_req0 = 1'b0; rd_req = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Test 5: random stream of 40 pops starting at count 8, against a queue model
    pulse_reset();
    q.delete();
    for (int n = 0; n < 8; n++) begin
      push0(8'(8'h10 + n));
      q.push_back(8'(8'h10 + n));
    end
    cnt_m = 8; last_m = 1'b0; popped = 0; cyc = 0;
    while (popped < 40 && cyc < 2000) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      e0 = r0 && (cnt_m != 16) && (!r1 || last_m);
      e1 = r1 && (cnt_m != 16) && (!r0 || !last_m);
      ea = rd && (cnt_m != 0);
      wr_req0 = r0; wr_req1 = r1; rd_req = rd; wr_data0 = d0; wr_data1 = d1;
      #1;
      chk("t5_gnt0", wr_gnt0, e0);
      chk("t5_gnt1", wr_gnt1, e1);
      chk("t5_rd_ack", rd_ack, ea);
      if (ea) chk("t5_rd_data", rd_data, q[0]);
      tick();
      if (ea) begin
        void'(q.pop_front());
        popped++;
      end
      if (e0) q.push_back(d0);
      if (e1) q.push_back(d1);
      if (e0 || e1) last_m = e1;
      cnt_m = cnt_m + int'(e0 || e1) - int'(ea);
      chk("t5_count", count, cnt_m);
      cyc++;
    end
    chk("t5_done", popped >= 40, 1);
    wr_req0 = 1'b0; wr_req1 = 1'b0; rd_req = 1'b0;

    // Test 6: asynchronous reset mid-stream at count 9
    pulse_reset();
    for (int n = 0; n < 9; n++) push0(8'(n));
    chk("t6_count9", count, 9);
    wr_req0 = 1'b1; wr_req1 = 1'b1; rd_req = 1'b1;
    wr_data0 = 8'hC0; wr_data1 = 8'hD0;
    #2;
    reset = 1'b0;
    #1;
    chk("t6_count0", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_gnt0", wr_gnt0, 0);
    chk("t6_gnt1", wr_gnt1, 0);
    chk("t6_rd_ack", rd_ack, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_post_gnt0", wr_gnt0, 1);
    chk("t6_post_gnt1", wr_gnt1, 0);
    rd_req = 1'b0;
    tick();
    chk("t6_post_count", count, 1);
    wr_req0 = 1'b0; wr_req1 = 1'b0;
    #1;
    chk("t6_post_rdata", rd_data, 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
